conv_pass_scheduler: RTL and testbench

- Sequences the conv-layer input feeder (picture window streamer plus weight ROM) over one or more passes per command.
- Per pass: pulses the feeder start, counts streamed taps/windows, and emits tap/window framing aligned to the feeder's registered map/weight outputs. The downstream MAC/accumulator uses this framing to clear and dump partial sums.
- Sits between the layer control FSM (command side) and the feeder plus MAC array (datapath side).

---
 rtl/conv_pass_scheduler_pkg.sv | 36 +++
 rtl/conv_pass_scheduler_tap_frame_pipe.sv | 63 ++++++
 rtl/conv_pass_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_conv_pass_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pass_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pass_scheduler_pkg
// Description : Shared definitions for the conv-layer pass scheduler.
//               Holds the FSM state encoding and the per-pass geometry
//               constants, plus helpers that derive them from any geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pass_scheduler_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LAUNCH   = 3'd1;
    localparam logic [2:0] ST_WAIT_RDY = 3'd2;
    localparam logic [2:0] ST_STREAM   = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;
    localparam logic [2:0] ST_NEXT     = 3'd5;

    // Default layer geometry (5x5 filter, 62x24 output windows)
    localparam int WEIGHT_NUM_DEF = 25;
    localparam int OUT_H_DEF      = 62;
    localparam int OUT_L_DEF      = 24;

    function automatic int tap_last_of(input int weight_num);
        return weight_num - 1;
    endfunction

    function automatic int taps_per_pass(input int weight_num, input int out_h, input int out_l);
        return weight_num * out_h * out_l;
    endfunction

    localparam int TAP_LAST      = tap_last_of(WEIGHT_NUM_DEF);
    localparam int TAPS_PER_PASS = taps_per_pass(WEIGHT_NUM_DEF, OUT_H_DEF, OUT_L_DEF);

endpackage
`default_nettype wire

// File: rtl/conv_pass_scheduler_tap_frame_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tap_frame_pipe
// Description : DEPTH-stage delay line for a valid bit plus sideband data.
//               Aligns beat framing with the feeder's registered outputs.
//               Sideband is zeroed on non-valid beats so framing outputs are
//               only ever non-zero alongside valid. flush clears every stage
//               on the next clock edge.
// Ports       : clk_in, rst_n (async active-low), flush,
//               in_valid/in_data -> out_valid/out_data (DEPTH cycles later)
// Revision    : 1.0 - initial release
// ============================================================================
module tap_frame_pipe
    import conv_pass_scheduler_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]             r_valid;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic              w_v_in;
            logic [DATA_W-1:0] w_d_in;

            if (gi == 0) begin : g_head
                assign w_v_in = in_valid;
                assign w_d_in = in_valid ? in_data : '0;
            end else begin : g_tail
                assign w_v_in = r_valid[gi-1];
                assign w_d_in = r_data[gi-1];
            end

            always_ff @(posedge clk_in or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[gi] <= 1'b0;
                    r_data[gi]  <= '0;
                end else if (flush) begin
                    r_valid[gi] <= 1'b0;
                    r_data[gi]  <= '0;
                end else begin
                    r_valid[gi] <= w_v_in;
                    r_data[gi]  <= w_d_in;
                end
            end
        end
    endgenerate

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv_pass_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv_pass_scheduler
// Description : Runs the conv-layer input feeder for one or more passes per
//               command. Each pass pulses feed_start, counts feed_ready beats
//               into tap / window indices, and emits tap framing delayed by
//               PIPE_LAT so it lines up with the feeder's map/weight outputs.
// Ports       : command side  - cmd_valid/cmd_ready/cmd_passes, abort
//               feeder side   - feed_start, feed_ready
//               MAC side      - tap_valid/first/last, win_h, win_l, pass_idx
//               status        - busy, done, aborted, err_underrun
// Revision    : 1.0 - initial release
// ============================================================================
module conv_pass_scheduler
    import conv_pass_scheduler_pkg::*;
#(
    parameter int WEIGHT_NUM   = 25,
    parameter int WEIGHT_NUM_2 = 5,
    parameter int OUT_H        = 62,
    parameter int OUT_H_2      = 6,
    parameter int OUT_L        = 24,
    parameter int OUT_L_2      = 5,
    parameter int PASS_W       = 4,
    parameter int PIPE_LAT     = 2
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [PASS_W-1:0]  cmd_passes,
    input  logic               abort,
    output logic               feed_start,
    input  logic               feed_ready,
    output logic               tap_valid,
    output logic               tap_first,
    output logic               tap_last,
    output logic [OUT_H_2-1:0] win_h,
    output logic [OUT_L_2-1:0] win_l,
    output logic [PASS_W-1:0]  pass_idx,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               err_underrun
);

    localparam logic [WEIGHT_NUM_2-1:0] c_TAP_LAST = WEIGHT_NUM_2'(tap_last_of(WEIGHT_NUM));
    localparam logic [OUT_L_2-1:0]      c_L_LAST   = OUT_L_2'(OUT_L - 1);
    localparam logic [OUT_H_2-1:0]      c_H_LAST   = OUT_H_2'(OUT_H - 1);
    localparam logic [PASS_W-1:0]       c_PASS_ONE = PASS_W'(1);
    localparam int                      c_DRAIN_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [c_DRAIN_W-1:0]    c_DRAIN_LAST = c_DRAIN_W'(PIPE_LAT - 1);
    localparam int                      c_SIDE_W   = 2 + OUT_H_2 + OUT_L_2;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [WEIGHT_NUM_2-1:0] r_tap;
    logic [OUT_L_2-1:0]      r_win_l;
    logic [OUT_H_2-1:0]      r_win_h;
    logic [PASS_W-1:0]       r_passes;
    logic [PASS_W-1:0]       r_pass_idx;
    logic [c_DRAIN_W-1:0]    r_drain_cnt;
    logic                    r_done;
    logic                    r_aborted;
    logic                    r_err;

    logic                    w_abort;
    logic                    w_beat;
    logic                    w_tap_wrap;
    logic                    w_l_wrap;
    logic                    w_h_wrap;
    logic                    w_final;
    logic                    w_last_pass;
    logic [c_SIDE_W-1:0]     w_side_in;
    logic [c_SIDE_W-1:0]     w_side_out;

    // Abort is only meaningful once a command is running.
    assign w_abort     = abort && (r_state != ST_IDLE);
    // A beat is any ready cycle while waiting or streaming; abort wins over it.
    assign w_beat      = feed_ready && !w_abort &&
                         ((r_state == ST_WAIT_RDY) || (r_state == ST_STREAM));
    assign w_tap_wrap  = (r_tap == c_TAP_LAST);
    assign w_l_wrap    = (r_win_l == c_L_LAST);
    assign w_h_wrap    = (r_win_h == c_H_LAST);
    assign w_final     = w_tap_wrap && w_l_wrap && w_h_wrap;
    assign w_last_pass = (r_passes == '0) || (r_pass_idx == (r_passes - c_PASS_ONE));
    assign w_side_in   = {(r_tap == '0), w_tap_wrap, r_win_h, r_win_l};

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        // A zero-pass command completes without touching the feeder.
                        w_state_nxt = (cmd_passes == '0) ? ST_NEXT : ST_LAUNCH;
                    end
                end
                ST_LAUNCH:   w_state_nxt = ST_WAIT_RDY;
                ST_WAIT_RDY,
                ST_STREAM: begin
                    if (w_beat) begin
                        w_state_nxt = w_final ? ST_DRAIN : ST_STREAM;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == c_DRAIN_LAST) begin
                        w_state_nxt = ST_NEXT;
                    end
                end
                ST_NEXT:     w_state_nxt = w_last_pass ? ST_IDLE : ST_LAUNCH;
                default:     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_tap       <= '0;
            r_win_l     <= '0;
            r_win_h     <= '0;
            r_passes    <= '0;
            r_pass_idx  <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= 1'b0;
            r_aborted <= w_abort;
            if (!w_abort) begin
                case (r_state)
                    ST_IDLE: begin
                        if (cmd_valid) begin
                            r_passes   <= cmd_passes;
                            r_pass_idx <= '0;
                            r_err      <= 1'b0;
                        end
                    end
                    ST_LAUNCH: begin
                        r_tap       <= '0;
                        r_win_l     <= '0;
                        r_win_h     <= '0;
                        r_drain_cnt <= '0;
                    end
                    ST_WAIT_RDY,
                    ST_STREAM: begin
                        if (w_beat) begin
                            if (w_tap_wrap) begin
                                r_tap <= '0;
                                if (w_l_wrap) begin
                                    r_win_l <= '0;
                                    r_win_h <= w_h_wrap ? '0 : r_win_h + 1'b1;
                                end else begin
                                    r_win_l <= r_win_l + 1'b1;
                                end
                            end else begin
                                r_tap <= r_tap + 1'b1;
                            end
                        end else if (r_state == ST_STREAM) begin
                            // Feeder stalled mid-pass: flag it, counting just pauses.
                            r_err <= 1'b1;
                        end
                    end
                    ST_DRAIN:    r_drain_cnt <= r_drain_cnt + 1'b1;
                    ST_NEXT: begin
                        if (w_last_pass) begin
                            r_done <= 1'b1;
                        end else begin
                            r_pass_idx <= r_pass_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    tap_frame_pipe #(
        .DATA_W (c_SIDE_W),
        .DEPTH  (PIPE_LAT)
    ) u_tap_frame_pipe (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .flush     (w_abort),
        .in_valid  (w_beat),
        .in_data   (w_side_in),
        .out_valid (tap_valid),
        .out_data  (w_side_out)
    );

    assign {tap_first, tap_last, win_h, win_l} = w_side_out;

    assign cmd_ready    = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign feed_start   = (r_state == ST_LAUNCH);
    assign pass_idx     = r_pass_idx;
    assign done         = r_done;
    assign aborted      = r_aborted;
    assign err_underrun = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_pass_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_conv_pass_scheduler
// Description : Self-checking bench for conv_pass_scheduler using a small
//               geometry (4 taps, 2x3 windows, 2-cycle pipe). A cycle-based
//               reference model derives every expected output from the
//               command, the ready pattern it drives and the pass rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_pass_scheduler;

    localparam int WN    = 4;
    localparam int WN_W  = 2;
    localparam int OH    = 2;
    localparam int OH_W  = 1;
    localparam int OL    = 3;
    localparam int OL_W  = 2;
    localparam int PW    = 4;
    localparam int PL    = 2;
    localparam int TOTAL = WN * OH * OL;

    logic            clk_in = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [PW-1:0]   cmd_passes = '0;
    logic            abort = 1'b0;
    logic            feed_start;
    logic            feed_ready = 1'b0;
    logic            tap_valid;
    logic            tap_first;
    logic            tap_last;
    logic [OH_W-1:0] win_h;
    logic [OL_W-1:0] win_l;
    logic [PW-1:0]   pass_idx;
    logic            busy;
    logic            done;
    logic            aborted;
    logic            err_underrun;

    int checks = 0;
    int passed = 0;
    bit model_err = 1'b0;

    typedef struct {
        int cyc;
        int k;
        int pass;
    } beat_t;

    conv_pass_scheduler #(
        .WEIGHT_NUM   (WN),
        .WEIGHT_NUM_2 (WN_W),
        .OUT_H        (OH),
        .OUT_H_2      (OH_W),
        .OUT_L        (OL),
        .OUT_L_2      (OL_W),
        .PASS_W       (PW),
        .PIPE_LAT     (PL)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_passes   (cmd_passes),
        .abort        (abort),
        .feed_start   (feed_start),
        .feed_ready   (feed_ready),
        .tap_valid    (tap_valid),
        .tap_first    (tap_first),
        .tap_last     (tap_last),
        .win_h        (win_h),
        .win_l        (win_l),
        .pass_idx     (pass_idx),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .err_underrun (err_underrun)
    );

    always #5 clk_in = ~clk_in;

    // Runs one command cycle by cycle. Interval t starts at a rising edge;
    // accept happens in interval 0. Beat k counted in interval c must show
    // up on tap_valid in interval c+PL; a pass ends PL drain cycles plus one
    // NEXT cycle after its last beat, and the next launch/done lands one
    // cycle after that.
    task automatic run_cmd(input string tag, input int passes, input int gap,
                           input int drop_at, input int drop_len, input int abort_at,
                           input bit abort_w_cmd, input bit rnd_drops, input int rst_at,
                           output int n_taps, output int n_starts);
        beat_t           q[$];
        beat_t           e;
        int              launch_t, done_t, abort_t, end_busy, stream_start;
        int              beats, pass, drop_left, extra_at;
        bit              in_pass, err_pending, rdy, e_fs, e_busy, e_valid;
        logic [1:0]      e_fl;
        logic [OH_W-1:0] e_h;
        logic [OL_W-1:0] e_l;
        logic [PW-1:0]   e_pass;
        launch_t     = (passes > 0) ? 1 : -1;
        done_t       = (passes > 0) ? -1 : 2;
        end_busy     = (passes > 0) ? (1 << 30) : 2;
        abort_t      = -10;
        stream_start = 0;
        beats        = 0;
        pass         = -1;
        drop_left    = drop_len;
        extra_at     = -1;
        in_pass      = 1'b0;
        err_pending  = 1'b0;
        n_taps       = 0;
        n_starts     = 0;
        for (int t = 0; t <= end_busy + 3; t++) begin
            if (t > 3000) begin
                checks++;
                $display("FAIL %s timeout: reached cycle %0d, required completion by 3000", tag, t);
                break;
            end
            @(posedge clk_in);
            #1;
            if (t == 1) model_err = 1'b0;
            if (err_pending) model_err = 1'b1;
            err_pending = 1'b0;
            e_fs   = (t == launch_t);
            e_busy = (t >= 1) && (t < end_busy);
            cmd_valid  = (t == 0);
            cmd_passes = PW'(passes);
            abort      = (t == 0) && abort_w_cmd;
            feed_ready = 1'b0;
            if (e_fs) begin
                in_pass      = 1'b1;
                pass++;
                beats        = 0;
                stream_start = t + gap;
            end
            if (in_pass && t >= stream_start && beats < TOTAL) begin
                if (pass == 0 && beats == rst_at) begin
                    feed_ready = 1'b1;
                    #2;
                    rst_n = 1'b0;
                    #1;
                    checks++;
                    if ({feed_start, tap_valid, tap_first, tap_last, win_h, win_l, pass_idx,
                         busy, done, aborted, err_underrun, cmd_ready} !== 20'd1)
                        $display("FAIL %s async_reset outputs: got %b, required %b", tag,
                                 {feed_start, tap_valid, tap_first, tap_last, win_h, win_l, pass_idx,
                                  busy, done, aborted, err_underrun, cmd_ready}, 20'd1);
                    else
                        passed++;
                    feed_ready = 1'b0;
                    cmd_valid  = 1'b0;
                    @(posedge clk_in);
                    @(negedge clk_in);
                    rst_n     = 1'b1;
                    model_err = 1'b0;
                    return;
                end else if (pass == 0 && beats == abort_at) begin
                    feed_ready = 1'b1;
                    abort      = 1'b1;
                    abort_t    = t;
                    end_busy   = t + 1;
                    in_pass    = 1'b0;
                    while (q.size() > 0 && q[q.size()-1].cyc > t) q.delete(q.size() - 1);
                end else begin
                    rdy = 1'b1;
                    if (pass == 0 && beats == drop_at && drop_left > 0) begin
                        rdy = 1'b0;
                        drop_left--;
                    end else if (rnd_drops && beats > 0 && $urandom_range(0, 4) == 0) begin
                        rdy = 1'b0;
                    end
                    feed_ready = rdy;
                    if (rdy) begin
                        q.push_back('{t + PL, beats, pass});
                        beats++;
                        if (beats == TOTAL) begin
                            extra_at = t + 1;
                            if (pass == passes - 1) begin
                                done_t   = t + PL + 2;
                                end_busy = done_t;
                            end else begin
                                launch_t = t + PL + 2;
                            end
                        end
                    end else if (beats > 0) begin
                        err_pending = 1'b1;
                    end
                end
            end else if (t == extra_at) begin
                // Feeder keeps ready one extra cycle after its last tap.
                feed_ready = 1'b1;
            end

            @(negedge clk_in);
            e_valid = 1'b0;
            e_fl    = 2'b00;
            e_h     = '0;
            e_l     = '0;
            e_pass  = '0;
            if (q.size() > 0 && q[0].cyc == t) begin
                e       = q.pop_front();
                e_valid = 1'b1;
                e_fl    = {(e.k % WN) == 0, (e.k % WN) == WN - 1};
                e_l     = OL_W'((e.k / WN) % OL);
                e_h     = OH_W'(e.k / (WN * OL));
                e_pass  = PW'(e.pass);
            end
            checks++;
            if (tap_valid !== e_valid)
                $display("FAIL %s tap_valid t=%0d: got %b, required %b", tag, t, tap_valid, e_valid);
            else
                passed++;
            checks++;
            if (e_valid && {tap_first, tap_last, win_h, win_l, pass_idx} !== {e_fl, e_h, e_l, e_pass})
                $display("FAIL %s framing t=%0d: got first/last=%b h=%0d l=%0d pass=%0d, required first/last=%b h=%0d l=%0d pass=%0d",
                         tag, t, {tap_first, tap_last}, win_h, win_l, pass_idx, e_fl, e_h, e_l, e_pass);
            else if (!e_valid && {tap_first, tap_last} !== 2'b00)
                $display("FAIL %s idle_framing t=%0d: got first/last=%b, required 00", tag, t, {tap_first, tap_last});
            else
                passed++;
            checks++;
            if (feed_start !== e_fs)
                $display("FAIL %s feed_start t=%0d: got %b, required %b", tag, t, feed_start, e_fs);
            else
                passed++;
            checks++;
            if (done !== (t == done_t))
                $display("FAIL %s done t=%0d: got %b, required %b", tag, t, done, (t == done_t));
            else
                passed++;
            checks++;
            if (aborted !== (t == abort_t + 1))
                $display("FAIL %s aborted t=%0d: got %b, required %b", tag, t, aborted, (t == abort_t + 1));
            else
                passed++;
            checks++;
            if ({busy, cmd_ready} !== {e_busy, !e_busy})
                $display("FAIL %s busy/cmd_ready t=%0d: got %b, required %b", tag, t, {busy, cmd_ready}, {e_busy, !e_busy});
            else
                passed++;
            checks++;
            if (err_underrun !== model_err)
                $display("FAIL %s err_underrun t=%0d: got %b, required %b", tag, t, err_underrun, model_err);
            else
                passed++;
            n_taps   += int'(tap_valid);
            n_starts += int'(feed_start);
        end
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        feed_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if ({feed_start, tap_valid, tap_first, tap_last, win_h, win_l, pass_idx,
             busy, done, aborted, err_underrun, cmd_ready} !== 20'd1)
            $display("FAIL reset_state: got %b, required %b",
                     {feed_start, tap_valid, tap_first, tap_last, win_h, win_l, pass_idx,
                      busy, done, aborted, err_underrun, cmd_ready}, 20'd1);
        else
            passed++;
        rst_n = 1'b1;
        @(negedge clk_in);
        checks++;
        if ({busy, cmd_ready, tap_valid} !== 3'b010)
            $display("FAIL post_reset_idle: got %b, required 010", {busy, cmd_ready, tap_valid});
        else
            passed++;
    endtask

    task automatic test_single_pass();
        int nt, ns;
        run_cmd("single", 1, 3, -1, 0, -1, 1'b0, 1'b0, -1, nt, ns);
        checks++;
        if (nt != TOTAL || ns != 1)
            $display("FAIL single totals: got taps=%0d starts=%0d, required taps=%0d starts=1", nt, ns, TOTAL);
        else
            passed++;
    endtask

    task automatic test_multi_pass();
        int nt, ns;
        run_cmd("multi", 3, int'($urandom_range(1, 4)), -1, 0, -1, 1'b0, 1'b0, -1, nt, ns);
        checks++;
        if (nt != 3 * TOTAL || ns != 3)
            $display("FAIL multi totals: got taps=%0d starts=%0d, required taps=%0d starts=3", nt, ns, 3 * TOTAL);
        else
            passed++;
    endtask

    task automatic test_underrun();
        int nt, ns;
        run_cmd("underrun", 1, 2, 6, 2, -1, 1'b0, 1'b0, -1, nt, ns);
        checks++;
        if (nt != TOTAL || err_underrun !== 1'b1)
            $display("FAIL underrun totals: got taps=%0d err=%b, required taps=%0d err=1", nt, err_underrun, TOTAL);
        else
            passed++;
        run_cmd("err_clear", 1, 1, -1, 0, -1, 1'b0, 1'b0, -1, nt, ns);
        checks++;
        if (err_underrun !== 1'b0)
            $display("FAIL err_clear: got %b, required 0", err_underrun);
        else
            passed++;
    endtask

    task automatic test_abort();
        int nt, ns;
        run_cmd("abort", 2, 3, -1, 0, 10, 1'b0, 1'b0, -1, nt, ns);
        checks++;
        if (nt != 10 - PL + 1 || ns != 1)
            $display("FAIL abort totals: got taps=%0d starts=%0d, required taps=%0d starts=1", nt, ns, 10 - PL + 1);
        else
            passed++;
        run_cmd("abort_w_cmd", 1, 2, -1, 0, -1, 1'b1, 1'b0, -1, nt, ns);
        checks++;
        if (nt != TOTAL)
            $display("FAIL abort_w_cmd totals: got taps=%0d, required %0d", nt, TOTAL);
        else
            passed++;
    endtask

    task automatic test_zero_passes();
        int nt, ns;
        run_cmd("zero", 0, 1, -1, 0, -1, 1'b0, 1'b0, -1, nt, ns);
        checks++;
        if (nt != 0 || ns != 0)
            $display("FAIL zero totals: got taps=%0d starts=%0d, required 0/0", nt, ns);
        else
            passed++;
    endtask

    task automatic test_async_reset();
        int nt, ns;
        run_cmd("rst_mid", 1, 2, -1, 0, -1, 1'b0, 1'b0, 9, nt, ns);
        run_cmd("after_rst", 2, 2, -1, 0, -1, 1'b0, 1'b0, -1, nt, ns);
        checks++;
        if (nt != 2 * TOTAL || ns != 2)
            $display("FAIL after_rst totals: got taps=%0d starts=%0d, required taps=%0d starts=2", nt, ns, 2 * TOTAL);
        else
            passed++;
    endtask

    task automatic test_random();
        int nt, ns, np;
        for (int i = 0; i < 4; i++) begin
            np = int'($urandom_range(1, 3));
            run_cmd("random", np, int'($urandom_range(1, 4)), -1, 0, -1, 1'b0, 1'b1, -1, nt, ns);
            checks++;
            if (nt != np * TOTAL || ns != np)
                $display("FAIL random totals: got taps=%0d starts=%0d, required taps=%0d starts=%0d",
                         nt, ns, np * TOTAL, np);
            else
                passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_underrun();
        test_abort();
        test_zero_passes();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
